frogger_game_ctrl: RTL and testbench

- Game sequencer for the road-crossing game. Each frame it advances the six car X positions that feed color_generation, and it detects player/car collisions and goal reach.
- Tracks lives and level, and runs the IDLE/PLAY/HIT/LEVEL_UP/GAME_OVER flow.
- Sits between the VGA counters, the player-movement block (which it resets through player_rst) and color_generation.

---
 rtl/frogger_game_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_frogger_game_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frogger_game_ctrl.sv
// frogger_game_ctrl
//   Game sequencer for the road-crossing game. It derives a once-per-frame
//   tick from the VGA counters. On each tick it advances the six car X
//   positions, checks the player against every lane for collisions and
//   checks for goal reach. It tracks lives and level and runs the
//   IDLE/PLAY/HIT/LEVEL_UP/GAME_OVER flow.
//
// Ports
//   CLK, RST_N          system clock, asynchronous active-low reset
//   start               one-cycle start/restart pulse (IDLE/GAME_OVER only)
//   h_count, v_count    VGA raster counters
//   player_x, player_y  player top-left corner
//   car_x1..car_x6      registered car left X positions
//   player_rst          one-cycle pulse returning the player to its start
//   frame_tick          one-cycle pulse per frame
//   state               IDLE=0 PLAY=1 HIT=2 LEVEL_UP=3 GAME_OVER=4
//   lives, level        remaining lives, current level
module frogger_game_ctrl #(
    parameter int          H_DISPLAY     = 640,
    parameter int          V_DISPLAY     = 480,
    parameter int          CAR_WIDTH     = 32,
    parameter int          CAR_HEIGHT    = 32,
    parameter int          PLAYER_WIDTH  = 32,
    parameter int          PLAYER_HEIGHT = 32,
    parameter int          LANE_Y0       = 96,
    parameter int          LANE_PITCH    = 48,
    parameter int          INIT_SPACING  = 96,
    parameter int          GOAL_Y        = 32,
    parameter logic [17:0] SPEED_PACK    = 18'o213121,
    parameter int          LIVES_INIT    = 3,
    parameter int          MAX_LEVEL     = 7,
    parameter int          PAUSE_FRAMES  = 60
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic [9:0] car_x1,
    output logic [9:0] car_x2,
    output logic [9:0] car_x3,
    output logic [9:0] car_x4,
    output logic [9:0] car_x5,
    output logic [9:0] car_x6,
    output logic       player_rst,
    output logic       frame_tick,
    output logic [2:0] state,
    output logic [1:0] lives,
    output logic [2:0] level
);

    localparam int NUM_CARS = 6;
    localparam int TW       = $clog2(PAUSE_FRAMES + 1);

    localparam logic [10:0] H_W  = 11'(H_DISPLAY);
    localparam logic [10:0] CW_W = 11'(CAR_WIDTH);
    localparam logic [10:0] CH_W = 11'(CAR_HEIGHT);
    localparam logic [10:0] PW_W = 11'(PLAYER_WIDTH);
    localparam logic [10:0] PH_W = 11'(PLAYER_HEIGHT);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_HIT       = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [NUM_CARS-1:0][9:0]   car_x_q, car_x_d;
    logic [NUM_CARS-1:0][9:0]   car_init;
    logic [NUM_CARS-1:0][9:0]   car_step;
    logic [NUM_CARS-1:0]        lane_hit;
    logic [1:0]                 lives_q, lives_d;
    logic [2:0]                 level_q, level_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic                       cond_q, cond_d;
    logic                       frame_tick_q, frame_tick_d;
    logic                       player_rst_q, player_rst_d;
    logic                       collision, win;
    logic [10:0]                px_ext, py_ext;

    assign px_ext = {1'b0, player_x};
    assign py_ext = {1'b0, player_y};

    // Per-lane speed, next position and overlap test. Even indices are
    // the odd-numbered lanes (1,3,5), which travel right.
    for (genvar gi = 0; gi < NUM_CARS; gi++) begin : g_lane
        localparam logic [10:0] LANE_Y = 11'(LANE_Y0 + gi * LANE_PITCH);
        logic [3:0]  speed;
        logic [10:0] x_ext, s_ext;

        assign speed = {1'b0, SPEED_PACK[3*gi +: 3]} + {1'b0, level_q};
        assign x_ext = {1'b0, car_x_q[gi]};
        assign s_ext = {7'd0, speed};
        assign car_init[gi] = 10'(gi * INIT_SPACING);

        if ((gi % 2) == 0) begin : g_right
            logic [10:0] fwd;
            assign fwd = x_ext + s_ext;
            assign car_step[gi] = (fwd >= H_W) ? 10'(fwd - H_W) : fwd[9:0];
        end else begin : g_left
            assign car_step[gi] = (x_ext < s_ext) ? 10'(x_ext + H_W - s_ext)
                                                  : 10'(x_ext - s_ext);
        end

        // Strict rectangle overlap against the pre-update car position.
        assign lane_hit[gi] = (px_ext < x_ext + CW_W) && (x_ext < px_ext + PW_W) &&
                              (py_ext < LANE_Y + CH_W) && (LANE_Y < py_ext + PH_W);
    end

    assign collision = |lane_hit;
    assign win       = (py_ext < 11'(GOAL_Y));

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            car_x_q      <= car_init;
            lives_q      <= 2'(LIVES_INIT);
            level_q      <= 3'd0;
            timer_q      <= '0;
            cond_q       <= 1'b0;
            frame_tick_q <= 1'b0;
            player_rst_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            car_x_q      <= car_x_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            timer_q      <= timer_d;
            cond_q       <= cond_d;
            frame_tick_q <= frame_tick_d;
            player_rst_q <= player_rst_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        car_x_d      = car_x_q;
        lives_d      = lives_q;
        level_d      = level_q;
        timer_d      = timer_q;
        player_rst_d = 1'b0;
        cond_d       = (v_count == 10'(V_DISPLAY)) && (h_count == 10'd0);
        // Rising edge only, so a held raster condition gives a single tick.
        frame_tick_d = cond_d && !cond_q;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                // start has priority over any tick in the same cycle.
                if (start) begin
                    state_d      = ST_PLAY;
                    lives_d      = 2'(LIVES_INIT);
                    level_d      = 3'd0;
                    timer_d      = '0;
                    car_x_d      = car_init;
                    player_rst_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (frame_tick_q) begin
                    if (collision) begin
                        if (lives_q <= 2'd1) begin
                            state_d = ST_GAME_OVER;
                            lives_d = 2'd0;
                        end else begin
                            state_d = ST_HIT;
                            lives_d = lives_q - 2'd1;
                            timer_d = TW'(PAUSE_FRAMES);
                        end
                    end else if (win) begin
                        state_d = ST_LEVEL_UP;
                        level_d = (level_q >= 3'(MAX_LEVEL)) ? 3'(MAX_LEVEL)
                                                             : level_q + 3'd1;
                        timer_d = TW'(PAUSE_FRAMES);
                    end else begin
                        car_x_d = car_step;
                    end
                end
            end
            ST_HIT, ST_LEVEL_UP: begin
                if (frame_tick_q) begin
                    timer_d = timer_q - TW'(1);
                    if (timer_q == TW'(1)) begin
                        state_d      = ST_PLAY;
                        player_rst_d = 1'b1;
                        if (state_q == ST_LEVEL_UP) begin
                            car_x_d = car_init;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        car_x1     = car_x_q[0];
        car_x2     = car_x_q[1];
        car_x3     = car_x_q[2];
        car_x4     = car_x_q[3];
        car_x5     = car_x_q[4];
        car_x6     = car_x_q[5];
        player_rst = player_rst_q;
        frame_tick = frame_tick_q;
        state      = state_q;
        lives      = lives_q;
        level      = level_q;
    end

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Directed testbench for frogger_game_ctrl. Expected values are pushed to a
// scoreboard queue and popped when the matching DUT output is sampled.
// GOAL_Y is raised to 100 so that a player standing on lane 1 (y=96) is
// simultaneously colliding and in the goal zone, exercising the priority.
module tb_frogger_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [9:0] h_count, v_count, player_x, player_y;
    logic [9:0] car_x1, car_x2, car_x3, car_x4, car_x5, car_x6;
    logic       player_rst, frame_tick;
    logic [2:0] state;
    logic [1:0] lives;
    logic [2:0] level;

    always #5 clk = ~clk;

    frogger_game_ctrl #(.GOAL_Y(100)) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .start      (start),
        .h_count    (h_count),
        .v_count    (v_count),
        .player_x   (player_x),
        .player_y   (player_y),
        .car_x1     (car_x1),
        .car_x2     (car_x2),
        .car_x3     (car_x3),
        .car_x4     (car_x4),
        .car_x5     (car_x5),
        .car_x6     (car_x6),
        .player_rst (player_rst),
        .frame_tick (frame_tick),
        .state      (state),
        .lives      (lives),
        .level      (level)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // Reference car model: position after t moves at level lvl.
    int lvl = 0;
    int t   = 0;
    int init_x[6] = '{0, 96, 192, 288, 384, 480};
    int base_s[6] = '{1, 2, 1, 3, 1, 2};
    logic [9:0] cars[6];

    always_comb begin
        cars[0] = car_x1; cars[1] = car_x2; cars[2] = car_x3;
        cars[3] = car_x4; cars[4] = car_x5; cars[5] = car_x6;
    end

    function automatic int model_x(int k);
        int s, v;
        s = base_s[k] + lvl;
        v = (k % 2 == 0) ? init_x[k] + s * t : init_x[k] - s * t;
        v = v % 640;
        if (v < 0) v += 640;
        return v;
    endfunction

    task automatic push(int v);
        exp_q.push_back(32'(v));
    endtask

    task automatic chk(string tag, logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%0d expected=<empty scoreboard>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
            end
        end
    endtask

    task automatic chk_val(string tag, logic [31:0] obs, int e);
        push(e);
        chk(tag, obs);
    endtask

    task automatic expect_cars(string tag);
        for (int k = 0; k < 6; k++) push(model_x(k));
        for (int k = 0; k < 6; k++) chk($sformatf("%s_car%0d", tag, k + 1), 32'(cars[k]));
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame: raster condition for one cycle, tick visible next cycle,
    // decision applied at the edge after that.
    task automatic tick(bit chk_ft);
        v_count = 10'd480; h_count = 10'd0;
        step(1);
        if (chk_ft) chk_val("frame_tick", 32'(frame_tick), 1);
        v_count = 10'd0; h_count = 10'd5;
        step(1);
    endtask

    task automatic chk_reset(string tag);
        lvl = 0; t = 0;
        chk_val({tag, "_state"}, 32'(state), 0);
        expect_cars(tag);
        chk_val({tag, "_lives"}, 32'(lives), 3);
        chk_val({tag, "_level"}, 32'(level), 0);
        chk_val({tag, "_player_rst"}, 32'(player_rst), 0);
        chk_val({tag, "_frame_tick"}, 32'(frame_tick), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        h_count = 10'd5; v_count = 10'd0;
        player_x = 10'd320; player_y = 10'd440;
        step(2);
        chk_reset("reset");
        rst_n = 1'b1;
        step(1);

        // Start from IDLE
        start = 1'b1; step(1); start = 1'b0;
        chk_val("start_state", 32'(state), 1);
        chk_val("start_prst", 32'(player_rst), 1);
        step(1);
        chk_val("prst_one_cycle", 32'(player_rst), 0);

        // First frame
        tick(1); t = 1;
        expect_cars("first");

        // Held raster condition gives a single move
        v_count = 10'd480; h_count = 10'd0;
        step(4);
        v_count = 10'd0; h_count = 10'd5;
        step(1); t = 2;
        expect_cars("held");

        // Run until car 1 wraps right and car 2 wraps left
        while (t < 641) begin
            tick(0); t++;
            if (t == 48 || t == 49 || t >= 638) expect_cars($sformatf("wrap_t%0d", t));
        end

        // Three collisions on lane 1 (player also in goal zone)
        player_x = 10'd0; player_y = 10'd96;
        for (int rep = 0; rep < 3; rep++) begin
            tick(1);
            if (rep < 2) begin
                chk_val("hit_state", 32'(state), 2);
                chk_val("hit_lives", 32'(lives), 2 - rep);
                expect_cars("hit_frozen");
                if (rep == 0) begin
                    start = 1'b1; step(1); start = 1'b0;
                    chk_val("hit_start_ignored", 32'(state), 2);
                    chk_val("hit_start_no_prst", 32'(player_rst), 0);
                end
                repeat (59) tick(0);
                chk_val("hit_59_ticks", 32'(state), 2);
                expect_cars("hit_59_frozen");
                tick(0);
                chk_val("hit_exit_state", 32'(state), 1);
                chk_val("hit_exit_prst", 32'(player_rst), 1);
                step(1);
                chk_val("hit_exit_prst_low", 32'(player_rst), 0);
            end else begin
                chk_val("over_state", 32'(state), 4);
                chk_val("over_lives", 32'(lives), 0);
            end
        end
        tick(0);
        chk_val("over_frozen_state", 32'(state), 4);
        expect_cars("over_frozen");

        // Restart from GAME_OVER
        player_x = 10'd320; player_y = 10'd440;
        start = 1'b1; step(1); start = 1'b0;
        t = 0;
        chk_val("restart_state", 32'(state), 1);
        chk_val("restart_lives", 32'(lives), 3);
        chk_val("restart_level", 32'(level), 0);
        chk_val("restart_prst", 32'(player_rst), 1);
        expect_cars("restart");

        // Eight wins, level saturates at 7
        for (int w = 1; w <= 8; w++) begin
            player_x = 10'd320; player_y = 10'd20;
            tick(0);
            chk_val("win_state", 32'(state), 3);
            chk_val("win_level", 32'(level), (w > 7) ? 7 : w);
            if (w == 8) begin
                player_x = 10'd0; player_y = 10'd96;
            end else begin
                player_y = 10'd440;
            end
            repeat (59) tick(0);
            chk_val("lvup_59_ticks", 32'(state), 3);
            tick(0);
            lvl = (w > 7) ? 7 : w; t = 0;
            chk_val("lvup_exit_state", 32'(state), 1);
            chk_val("lvup_exit_prst", 32'(player_rst), 1);
            expect_cars("lvup_reload");
            if (w == 1) begin
                tick(0); t = 1;
                expect_cars("lvl1_move1");
                tick(0); t = 2;
                expect_cars("lvl1_move2");
            end
        end

        // Collision and win together: collision wins
        tick(1);
        chk_val("both_state", 32'(state), 2);
        chk_val("both_level", 32'(level), 7);
        chk_val("both_lives", 32'(lives), 2);
        repeat (3) tick(0);

        // Asynchronous reset mid-HIT, between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        step(1);
        rst_n = 1'b1;
        player_x = 10'd320; player_y = 10'd440;

        // start in the same cycle as a tick in IDLE: no car move
        v_count = 10'd480; h_count = 10'd0;
        step(1);
        chk_val("idle_tick", 32'(frame_tick), 1);
        start = 1'b1; v_count = 10'd0; h_count = 10'd5;
        step(1); start = 1'b0;
        chk_val("start_tick_state", 32'(state), 1);
        expect_cars("start_tick_nomove");
        tick(0); t = 1;
        expect_cars("after_start_tick");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
